uart_xcvr: RTL and testbench

- Parametrised successor to the fixed 8N1 UART used by the SEM monitor link.
- Full-duplex serial transceiver with:
  - configurable data width, baud divisor, parity and stop bits;
  - a transmit handshake;
  - a receive FIFO with framing, parity and overrun error flags.
- Sits between the SEM controller/monitor logic and the board RS-232 pins.

---
 rtl/uart_xcvr_pkg.sv | 30 +++
 rtl/uart_xcvr_fifo.sv | 45 ++++
 rtl/uart_xcvr.sv | 208 ++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_xcvr_pkg.sv
// uart_xcvr_pkg: shared parity modes, FSM encodings and sizing helper for uart_xcvr.
package uart_xcvr_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_xcvr_fifo.sv
// uart_xcvr_fifo: synchronous FIFO with wrap-bit pointers; push while full is
// accepted only when a pop frees the head slot in the same cycle.
module uart_xcvr_fifo
    import uart_xcvr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART, TX handshake and RX FIFO with sticky errors.
// Define UART_XCVR_LOOPBACK_EN to add the loopback port (internal TX line -> RX input).
module uart_xcvr
    import uart_xcvr_pkg::*;
#(
    parameter int CLK_DIV   = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef UART_XCVR_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_par_err,
    output logic                 rx_overrun,
    input  logic                 err_clr,
    input  logic                 serial_in,
    output logic                 serial_out
);

    localparam int STOP_LEN = STOP_BITS * CLK_DIV;
    localparam int CW       = clog2(STOP_LEN + 1);
    localparam int BW       = clog2(DATA_BITS);

    localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_LEN - 1);
    localparam logic [CW-1:0] DONE_AT  = CW'(STOP_LEN - 2);
    localparam logic [BW-1:0] BIT_END  = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT  = (PARITY == PAR_ODD);
    localparam logic          HAS_PAR  = (PARITY != PAR_NONE);

    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par, tx_line, tx_tick;

    rx_state_t            rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_pbit, rx_src, sync1, rx_s, rx_prev, rx_tick;
    logic                 stop_smp, par_bad, push, pop, full, empty;

`ifdef UART_XCVR_LOOPBACK_EN
    assign rx_src     = loopback ? tx_line : serial_in;
    assign serial_out = loopback | tx_line;
`else
    assign rx_src     = serial_in;
    assign serial_out = tx_line;
`endif

    assign tx_tick = tx_cnt == DIV_END;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_cnt  <= tx_cnt + 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (tx_valid && tx_ready) begin
                        tx_state <= TX_START;
                        tx_sh    <= tx_data;
                        tx_par   <= ^tx_data ^ ODD_BIT;
                        tx_line  <= 1'b0;
                        tx_ready <= 1'b0;
                    end
                end
                TX_START: if (tx_tick) begin
                    tx_state <= TX_DATA;
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                    tx_line  <= tx_sh[0];
                end
                TX_DATA: if (tx_tick) begin
                    tx_cnt <= '0;
                    if (tx_bit == BIT_END) begin
                        tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
                        tx_line  <= HAS_PAR ? tx_par : 1'b1;
                    end else begin
                        tx_bit  <= tx_bit + 1'b1;
                        tx_sh   <= tx_sh >> 1;
                        tx_line <= tx_sh[1];
                    end
                end
                TX_PARITY: if (tx_tick) begin
                    tx_state <= TX_STOP;
                    tx_cnt   <= '0;
                    tx_line  <= 1'b1;
                end
                TX_STOP: begin
                    // registered pulse, so it is raised one cycle ahead to land on the last stop cycle
                    tx_done <= tx_cnt == DONE_AT;
                    if (tx_cnt == STOP_END) begin
                        tx_state <= TX_IDLE;
                        tx_ready <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_src;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign rx_tick  = rx_cnt == DIV_END;
    assign stop_smp = (rx_state == RX_STOP) && rx_tick;
    assign par_bad  = HAS_PAR && ((^rx_sh ^ rx_pbit) != ODD_BIT);
    assign push     = stop_smp && rx_s;
    assign pop      = rx_valid && rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_pbit  <= 1'b0;
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s) rx_state <= RX_START;
                end
                RX_START: if (rx_cnt == HALF_END) begin
                    rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                end
                RX_DATA: if (rx_tick) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == BIT_END) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: if (rx_tick) begin
                    rx_state <= RX_STOP;
                    rx_cnt   <= '0;
                    rx_pbit  <= rx_s;
                end
                RX_STOP: if (rx_tick) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_frame_err <= 1'b0;
            rx_par_err   <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= (stop_smp && !rx_s) || (rx_frame_err && !err_clr);
            rx_par_err   <= (push && par_bad) || (rx_par_err && !err_clr);
            rx_overrun   <= (push && full && !pop) || (rx_overrun && !err_clr);
        end
    end

    assign rx_valid = !empty;

    uart_xcvr_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(RX_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (rx_sh),
        .rd_en   (pop),
        .rd_data (rx_data),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: table vectors, directed corner sequences and randomized frames
// checked against a frame-level model (bit list, FIFO queue, sticky flags).
module tb_uart_xcvr;

    localparam int DIV   = 16;
    localparam int FRAME = 11 * DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_valid;
        logic       exp_par;
        logic       exp_frm;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic [7:0] tx_data = '0, rx_data;
    logic       tx_valid = 1'b0, tx_ready, tx_done;
    logic       rx_valid, rx_ready = 1'b0, err_clr = 1'b0;
    logic       rx_frame_err, rx_par_err, rx_overrun;
    logic       serial_out, serial_in, drv = 1'b1, lb = 1'b0;
    logic       seen_frm = 1'b0;
    logic [7:0] q[$];
    int         n_tests = 0, n_fail = 0;

    assign serial_in = lb ? serial_out : drv;

    always #5 clk = ~clk;

    uart_xcvr #(
        .CLK_DIV  (DIV),
        .DATA_BITS(8),
        .PARITY   (1),
        .STOP_BITS(1),
        .RX_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_par_err  (rx_par_err),
        .rx_overrun  (rx_overrun),
        .err_clr     (err_clr),
        .serial_in   (serial_in),
        .serial_out  (serial_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (tx_ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("tx_ready_wait", 32'(tx_ready), 1);
    endtask

    // Expected line: start, 8 data LSB first, even parity, stop; tx_done on the last cycle.
    task automatic send_tx(input logic [7:0] d);
        logic [10:0] bits;
        int bad, first;
        bits = {1'b1, ^d, d, 1'b0};
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        bad = 0;
        first = 0;
        for (int c = 1; c <= FRAME; c++) begin
            if (c > 1) @(negedge clk);
            if (serial_out !== bits[(c - 1) / DIV] || tx_done !== (c == FRAME) || tx_ready !== 1'b0) begin
                if (bad == 0) first = c;
                bad++;
            end
        end
        if (bad != 0) $display("tx frame 0x%0h: first deviation at cycle %0d", d, first);
        check("tx_frame_bad_cycles", bad, 0);
        @(negedge clk);
        check("tx_ready_after", 32'(tx_ready), 1);
    endtask

    task automatic serial_frame(input logic [7:0] d, input logic bp, input logic bs);
        logic [10:0] bits;
        bits = {~bs, ^d ^ bp, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            drv = bits[b];
            for (int k = 0; k < DIV; k++) begin
                @(negedge clk);
                if (rx_frame_err) seen_frm = 1'b1;
            end
        end
        drv = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_check(input logic [7:0] exp);
        check("pop_valid", 32'(rx_valid), 1);
        check("pop_data", 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] d;
        logic       bp, bs, m_par, m_frm, m_ovr;
        int         mode;

        vecs[0] = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial_out", 32'(serial_out), 1);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_tx_done", 32'(tx_done), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_flags", 32'({rx_frame_err, rx_par_err, rx_overrun}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        lb = 1'b1;
        send_tx(8'hAA);
        pop_check(8'hAA);
        send_tx(8'h07);
        check("lb_07_par_err", 32'(rx_par_err), 0);
        pop_check(8'h07);

        lb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            serial_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
            check("vec_valid", 32'(rx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check("vec_data", 32'(rx_data), 32'(vecs[i].data));
            check("vec_par_err", 32'(rx_par_err), 32'(vecs[i].exp_par));
            check("vec_frame_err", 32'(rx_frame_err), 32'(vecs[i].exp_frm));
            if (rx_valid) begin
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
            clear_err();
            check("vec_cleared", 32'({rx_frame_err, rx_par_err, rx_overrun, rx_valid}), 0);
        end

        err_clr  = 1'b1;
        seen_frm = 1'b0;
        serial_frame(8'h55, 1'b0, 1'b1);
        err_clr = 1'b0;
        check("set_beats_clear", 32'(seen_frm), 1);
        check("clear_after_set", 32'(rx_frame_err), 0);

        drv = 1'b0;
        repeat (5) @(negedge clk);
        drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", 32'(rx_valid), 0);
        check("glitch_flags", 32'({rx_frame_err, rx_par_err, rx_overrun}), 0);

        lb = 1'b1;
        for (int i = 1; i <= 5; i++) send_tx(8'(i));
        check("ovr_flag", 32'(rx_overrun), 1);
        for (int i = 1; i <= 4; i++) pop_check(8'(i));
        check("ovr_drained", 32'(rx_valid), 0);
        clear_err();

        wait_ready();
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (70) @(negedge clk);
        check("mid_bit3_low", 32'(serial_out), 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_serial_out", 32'(serial_out), 1);
        check("rst_mid_tx_ready", 32'(tx_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_empty", 32'(rx_valid), 0);
        send_tx(8'h3C);
        pop_check(8'h3C);

        q.delete();
        m_par = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            mode = $urandom_range(0, 2);
            bp   = 1'b0;
            bs   = 1'b0;
            if (mode == 0) begin
                lb = 1'b1;
                send_tx(d);
            end else begin
                lb = 1'b0;
                bp = ($urandom_range(0, 3) == 0);
                bs = !bp && ($urandom_range(0, 4) == 0);
                serial_frame(d, bp, bs);
            end
            if (bs) m_frm = 1'b1;
            else begin
                if (bp) m_par = 1'b1;
                if (q.size() == 4) m_ovr = 1'b1;
                else q.push_back(d);
            end
            check("rnd_valid", 32'(rx_valid), 32'(q.size() != 0));
            if (q.size() != 0) check("rnd_head", 32'(rx_data), 32'(q[0]));
            check("rnd_flags", 32'({rx_frame_err, rx_par_err, rx_overrun}), 32'({m_frm, m_par, m_ovr}));
            if (q.size() != 0 && $urandom_range(0, 2) != 0) begin
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                void'(q.pop_front());
            end
            if ($urandom_range(0, 3) == 0) begin
                clear_err();
                m_frm = 1'b0;
                m_par = 1'b0;
                m_ovr = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
